retire_trace_fifo: RTL and testbench

- Sits directly downstream of the dual-issue core model's retirement outputs.
- Captures up to two retired-instruction records per cycle, in program order, into a circular buffer.
- Drains one record per cycle to a valid/ready debug/trace consumer.
- The core cannot be stalled by tracing, so overflow drops records, counts them, and flags it.

---
 rtl/retire_trace_fifo_if.sv | 68 ++++++
 rtl/retire_trace_fifo.sv | 142 ++++++++++++++
 tb/tb_retire_trace_fifo.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_fifo_if.sv
// Retirement capture and trace-drain signal bundle for retire_trace_fifo.
// Defining RETIRE_TRACE_SEQ_EN adds the rd_seq_o record tag.
interface retire_trace_fifo_if #(
  parameter int unsigned IssueWidth = 2,
  parameter int unsigned Depth      = 16,
  parameter int unsigned DropCntW   = 16,
  parameter int unsigned XLEN       = 32
);
  logic                            clr_i;
  logic [IssueWidth-1:0]           update_i;
  logic [IssueWidth-1:0][XLEN-1:0] pc_i;
  logic [IssueWidth-1:0][XLEN-1:0] instr_i;
  logic [IssueWidth-1:0][4:0]      reg_addr_i;
  logic [IssueWidth-1:0][XLEN-1:0] reg_data_i;
  logic [IssueWidth-1:0][XLEN-1:0] mem_addr_i;
  logic [IssueWidth-1:0][XLEN-1:0] mem_data_i;
  logic [IssueWidth-1:0]           mem_wrt_i;

  logic                            rd_valid_o;
  logic                            rd_ready_i;
  logic [XLEN-1:0]                 rd_pc_o;
  logic [XLEN-1:0]                 rd_instr_o;
  logic [4:0]                      rd_reg_addr_o;
  logic [XLEN-1:0]                 rd_reg_data_o;
  logic [XLEN-1:0]                 rd_mem_addr_o;
  logic [XLEN-1:0]                 rd_mem_data_o;
  logic                            rd_mem_wrt_o;

  logic [$clog2(Depth):0]          count_o;
  logic                            overflow_o;
  logic [DropCntW-1:0]             drop_cnt_o;

`ifdef RETIRE_TRACE_SEQ_EN
  logic [31:0]                     rd_seq_o;

  modport master (
    output clr_i, update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_instr_o, rd_reg_addr_o, rd_reg_data_o,
           rd_mem_addr_o, rd_mem_data_o, rd_mem_wrt_o, count_o, overflow_o,
           drop_cnt_o, rd_seq_o
  );

  modport slave (
    input  clr_i, update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_instr_o, rd_reg_addr_o, rd_reg_data_o,
           rd_mem_addr_o, rd_mem_data_o, rd_mem_wrt_o, count_o, overflow_o,
           drop_cnt_o, rd_seq_o
  );
`else
  modport master (
    output clr_i, update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, rd_ready_i,
    input  rd_valid_o, rd_pc_o, rd_instr_o, rd_reg_addr_o, rd_reg_data_o,
           rd_mem_addr_o, rd_mem_data_o, rd_mem_wrt_o, count_o, overflow_o,
           drop_cnt_o
  );

  modport slave (
    input  clr_i, update_i, pc_i, instr_i, reg_addr_i, reg_data_i,
           mem_addr_i, mem_data_i, mem_wrt_i, rd_ready_i,
    output rd_valid_o, rd_pc_o, rd_instr_o, rd_reg_addr_o, rd_reg_data_o,
           rd_mem_addr_o, rd_mem_data_o, rd_mem_wrt_o, count_o, overflow_o,
           drop_cnt_o
  );
`endif
endinterface

// File: rtl/retire_trace_fifo.sv
// Dual-retire trace buffer: captures up to two records per cycle, drains one.
// Defining RETIRE_TRACE_SEQ_EN tags each retired record with a 32-bit sequence number.
module retire_trace_fifo #(
  parameter int unsigned IssueWidth = 2,
  parameter int unsigned Depth      = 16,
  parameter int unsigned DropCntW   = 16,
  parameter int unsigned XLEN       = 32
) (
  input logic                clk_i,
  input logic                rstn_i,
  retire_trace_fifo_if.slave trc
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
`ifdef RETIRE_TRACE_SEQ_EN
    logic [31:0]     seq;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } rec_t;

  rec_t                mem [Depth];
  rec_t                slot [IssueWidth];
  rec_t                wr_first;
  rec_t                wr_second;
  rec_t                head;
  ptr_t                wptr;
  ptr_t                rptr;
  cnt_t                count;
  cnt_t                free;
  cnt_t                n_rec;
  cnt_t                n_acc;
  cnt_t                n_drop;
  logic                pop;
  logic                valid;
  logic                overflow;
  logic [DropCntW-1:0] drop_cnt;
  logic [DropCntW:0]   drop_sum;
`ifdef RETIRE_TRACE_SEQ_EN
  logic [31:0]         seq;
`endif

  always_comb begin
    for (int unsigned s = 0; s < IssueWidth; s++) begin
      slot[s].pc       = trc.pc_i[s];
      slot[s].instr    = trc.instr_i[s];
      slot[s].reg_addr = trc.reg_addr_i[s];
      slot[s].reg_data = trc.reg_data_i[s];
      slot[s].mem_addr = trc.mem_addr_i[s];
      slot[s].mem_data = trc.mem_data_i[s];
      slot[s].mem_wrt  = trc.mem_wrt_i[s];
`ifdef RETIRE_TRACE_SEQ_EN
      // Slot 1 follows slot 0 in program order only when slot 0 actually retired.
      slot[s].seq      = (s == 0) ? seq : seq + 32'(trc.update_i[0]);
`endif
    end

    n_rec  = cnt_t'(trc.update_i[0]) + cnt_t'(trc.update_i[1]);
    free   = cnt_t'(Depth) - count;
    n_acc  = (free >= n_rec) ? n_rec : free;
    n_drop = n_rec - n_acc;

    // The oldest valid record always lands at wptr; slot 1 follows only on dual retire.
    wr_first  = trc.update_i[0] ? slot[0] : slot[1];
    wr_second = slot[1];

    pop      = valid && trc.rd_ready_i;
    drop_sum = {1'b0, drop_cnt} + (DropCntW+1)'(n_drop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
`ifdef RETIRE_TRACE_SEQ_EN
      seq      <= '0;
`endif
    end else if (trc.clr_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
`ifdef RETIRE_TRACE_SEQ_EN
      seq      <= '0;
`endif
    end else begin
      wptr  <= wptr + ptr_t'(n_acc);
      count <= count + n_acc - cnt_t'(pop);
      if (pop) begin
        rptr <= rptr + ptr_t'(1);
      end
      if (n_drop != '0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[DropCntW] ? '1 : drop_sum[DropCntW-1:0];
      end
`ifdef RETIRE_TRACE_SEQ_EN
      seq <= seq + 32'(n_rec);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!trc.clr_i && n_acc != '0) begin
      mem[wptr] <= wr_first;
    end
    if (!trc.clr_i && n_acc == cnt_t'(2)) begin
      mem[wptr + ptr_t'(1)] <= wr_second;
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rptr];

  assign trc.rd_valid_o    = valid;
  assign trc.rd_pc_o       = valid ? head.pc       : '0;
  assign trc.rd_instr_o    = valid ? head.instr    : '0;
  assign trc.rd_reg_addr_o = valid ? head.reg_addr : '0;
  assign trc.rd_reg_data_o = valid ? head.reg_data : '0;
  assign trc.rd_mem_addr_o = valid ? head.mem_addr : '0;
  assign trc.rd_mem_data_o = valid ? head.mem_data : '0;
  assign trc.rd_mem_wrt_o  = valid ? head.mem_wrt  : 1'b0;
`ifdef RETIRE_TRACE_SEQ_EN
  assign trc.rd_seq_o      = valid ? head.seq      : '0;
`endif
  assign trc.count_o       = count;
  assign trc.overflow_o    = overflow;
  assign trc.drop_cnt_o    = drop_cnt;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_retire_trace_fifo;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wrt;
    logic [31:0] seq;
  } rec_t;

  typedef struct {
    logic [1:0]  upd;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        rdy;
    logic        clr;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_ovf;
    int          exp_drop;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  retire_trace_fifo_if #(.IssueWidth(2), .Depth(DEPTH), .DropCntW(16), .XLEN(32)) trc ();

  retire_trace_fifo #(.IssueWidth(2), .Depth(DEPTH), .DropCntW(16), .XLEN(32)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .trc    (trc)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  rec_t        mq[$];
  logic        m_ovf;
  int unsigned m_drop;
  logic [31:0] m_seq;
  logic [31:0] dut_pops[$];
  logic [1:0]  cur_upd;
  rec_t        cur_r[2];
  logic        cur_rdy;
  logic        cur_clr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t make_rec(input logic [31:0] pc);
    rec_t r;
    r.pc       = pc;
    r.instr    = $urandom;
    r.reg_addr = 5'($urandom);
    r.reg_data = $urandom;
    r.mem_addr = $urandom;
    r.mem_data = $urandom;
    r.mem_wrt  = 1'($urandom);
    r.seq      = '0;
    return r;
  endfunction

  task automatic drive(input logic [1:0] upd, input rec_t r0, input rec_t r1,
                       input logic rdy, input logic clr);
    cur_upd = upd; cur_r[0] = r0; cur_r[1] = r1; cur_rdy = rdy; cur_clr = clr;
    trc.update_i = upd;
    trc.rd_ready_i = rdy;
    trc.clr_i = clr;
    for (int s = 0; s < 2; s++) begin
      trc.pc_i[s]       = cur_r[s].pc;
      trc.instr_i[s]    = cur_r[s].instr;
      trc.reg_addr_i[s] = cur_r[s].reg_addr;
      trc.reg_data_i[s] = cur_r[s].reg_data;
      trc.mem_addr_i[s] = cur_r[s].mem_addr;
      trc.mem_data_i[s] = cur_r[s].mem_data;
      trc.mem_wrt_i[s]  = cur_r[s].mem_wrt;
    end
  endtask

  task automatic drive_idle(input logic rdy);
    drive(2'b00, make_rec(0), make_rec(0), rdy, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete(); m_ovf = 1'b0; m_drop = 0; m_seq = '0;
  endtask

  // Reference: occupancy and free space from the queue at the start of the cycle.
  task automatic model_edge();
    int   free;
    bit   do_pop;
    rec_t r;
    if (cur_clr) begin
      model_reset();
      return;
    end
    free   = DEPTH - mq.size();
    do_pop = (mq.size() != 0) && cur_rdy;
    if (do_pop) void'(mq.pop_front());
    for (int s = 0; s < 2; s++) begin
      if (cur_upd[s]) begin
        r = cur_r[s];
        r.seq = m_seq;
        m_seq++;
        if (free > 0) begin
          mq.push_back(r);
          free--;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic cycle();
    if (trc.rd_valid_o && trc.rd_ready_i && !trc.clr_i) dut_pops.push_back(trc.rd_pc_o);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, trc.rd_valid_o, mq.size() != 0);
    chk({tag, ".count"}, trc.count_o, mq.size());
    chk({tag, ".ovf"},   trc.overflow_o, m_ovf);
    chk({tag, ".drop"},  trc.drop_cnt_o, m_drop);
    if (mq.size() != 0) begin
      chk({tag, ".pc"},       trc.rd_pc_o,       mq[0].pc);
      chk({tag, ".instr"},    trc.rd_instr_o,    mq[0].instr);
      chk({tag, ".reg_addr"}, trc.rd_reg_addr_o, mq[0].reg_addr);
      chk({tag, ".reg_data"}, trc.rd_reg_data_o, mq[0].reg_data);
      chk({tag, ".mem_addr"}, trc.rd_mem_addr_o, mq[0].mem_addr);
      chk({tag, ".mem_data"}, trc.rd_mem_data_o, mq[0].mem_data);
      chk({tag, ".mem_wrt"},  trc.rd_mem_wrt_o,  mq[0].mem_wrt);
`ifdef RETIRE_TRACE_SEQ_EN
      chk({tag, ".seq"},      trc.rd_seq_o,      mq[0].seq);
`endif
    end else begin
      chk({tag, ".empty_pc"},    trc.rd_pc_o,    0);
      chk({tag, ".empty_instr"}, trc.rd_instr_o, 0);
    end
  endtask

  task automatic do_reset();
    drive_idle(1'b0);
    rstn = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[9];
    logic        prev_valid;
    logic [31:0] pcn;

    vt[0] = '{2'b11, 32'h100, 32'h104, 1'b0, 1'b0, 2, 1'b1, 32'h100, 1'b0, 0};
    vt[1] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 1, 1'b1, 32'h104, 1'b0, 0};
    vt[2] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h0,   1'b0, 0};
    vt[3] = '{2'b10, 32'h0,   32'h200, 1'b1, 1'b0, 1, 1'b1, 32'h200, 1'b0, 0};
    vt[4] = '{2'b01, 32'h300, 32'h0,   1'b1, 1'b0, 1, 1'b1, 32'h300, 1'b0, 0};
    vt[5] = '{2'b11, 32'h400, 32'h404, 1'b0, 1'b0, 3, 1'b1, 32'h300, 1'b0, 0};
    vt[6] = '{2'b11, 32'h500, 32'h504, 1'b1, 1'b1, 0, 1'b0, 32'h0,   1'b0, 0};
    vt[7] = '{2'b00, 32'h0,   32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h0,   1'b0, 0};
    vt[8] = '{2'b10, 32'h0,   32'h600, 1'b0, 1'b0, 1, 1'b1, 32'h600, 1'b0, 0};

    do_reset();
    chk("reset.valid", trc.rd_valid_o, 0);
    chk("reset.count", trc.count_o, 0);
    chk("reset.ovf",   trc.overflow_o, 0);
    chk("reset.drop",  trc.drop_cnt_o, 0);
    chk("reset.pc",    trc.rd_pc_o, 0);

    // Vector table
    prev_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].upd, make_rec(vt[i].pc0), make_rec(vt[i].pc1), vt[i].rdy, vt[i].clr);
      #1;
      chk($sformatf("tbl%0d.nocomb_valid", i), trc.rd_valid_o, prev_valid);
      cycle();
      chk($sformatf("tbl%0d.count", i), trc.count_o,    vt[i].exp_count);
      chk($sformatf("tbl%0d.valid", i), trc.rd_valid_o, vt[i].exp_valid);
      chk($sformatf("tbl%0d.pc", i),    trc.rd_pc_o,    vt[i].exp_pc);
      chk($sformatf("tbl%0d.ovf", i),   trc.overflow_o, vt[i].exp_ovf);
      chk($sformatf("tbl%0d.drop", i),  trc.drop_cnt_o, vt[i].exp_drop);
      prev_valid = vt[i].exp_valid;
    end

    // Partial acceptance with one free slot and a concurrent pop
    do_reset();
    pcn = 32'h1000;
    for (int i = 0; i < 7; i++) begin
      drive(2'b11, make_rec(pcn), make_rec(pcn + 4), 1'b0, 1'b0);
      pcn += 8;
      cycle();
    end
    drive(2'b01, make_rec(pcn), make_rec(0), 1'b0, 1'b0);
    pcn += 4;
    cycle();
    chk("fill15.count", trc.count_o, 15);
    drive(2'b11, make_rec(pcn), make_rec(pcn + 4), 1'b1, 1'b0);
    cycle();
    chk("partial.count", trc.count_o, 15);
    chk("partial.ovf",   trc.overflow_o, 1);
    chk("partial.drop",  trc.drop_cnt_o, 1);
    chk("partial.pc",    trc.rd_pc_o, 32'h1004);
    check_model("partial");

    // Full buffer: drops, then ordered drain
    do_reset();
    pcn = 32'h2000;
    for (int i = 0; i < 11; i++) begin
      drive(2'b11, make_rec(pcn), make_rec(pcn + 4), 1'b0, 1'b0);
      pcn += 8;
      cycle();
      if (i == 7) chk("full.count16", trc.count_o, 16);
    end
    chk("full.drop", trc.drop_cnt_o, 6);
    chk("full.count", trc.count_o, 16);
    chk("full.ovf", trc.overflow_o, 1);
    drive_idle(1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.pc", i), trc.rd_pc_o, 32'h2000 + 32'(4 * i));
      cycle();
    end
    chk("drain.valid", trc.rd_valid_o, 0);
    chk("drain.count", trc.count_o, 0);

    // Pointer wrap: 40 dual retires, one pop per cycle
    do_reset();
    dut_pops.delete();
    pcn = 32'h3000;
    for (int i = 0; i < 40; i++) begin
      drive(2'b11, make_rec(pcn), make_rec(pcn + 4), 1'b1, 1'b0);
      pcn += 8;
      cycle();
      check_model("wrap");
    end
    chk("wrap.npops", dut_pops.size(), 39);
    for (int i = 1; i < dut_pops.size(); i++)
      chk($sformatf("wrap.order%0d", i), dut_pops[i] > dut_pops[i-1], 1);

    // Clear on a half-full buffer with a concurrent dual retire
    drive_idle(1'b1);
    for (int k = 0; k < DEPTH && mq.size() > 8; k++) cycle();
    chk("half.count", trc.count_o, 8);
    chk("half.ovf", trc.overflow_o, 1);
    drive(2'b11, make_rec(32'h4000), make_rec(32'h4004), 1'b1, 1'b1);
    cycle();
    chk("clr.count", trc.count_o, 0);
    chk("clr.ovf",   trc.overflow_o, 0);
    chk("clr.drop",  trc.drop_cnt_o, 0);
    chk("clr.valid", trc.rd_valid_o, 0);
    drive_idle(1'b0);
    cycle();
    check_model("postclr");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, make_rec(32'h5000 + 32'(8 * i)), make_rec(32'h5004 + 32'(8 * i)), 1'b0, 1'b0);
      cycle();
    end
    chk("arst.pre_valid", trc.rd_valid_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst.valid", trc.rd_valid_o, 0);
    chk("arst.count", trc.count_o, 0);
    model_reset();
    drive_idle(1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_model("arst.post");

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      drive(2'($urandom), make_rec($urandom), make_rec($urandom),
            $urandom_range(0, 99) < ((c < 200) ? 30 : 70),
            $urandom_range(0, 63) == 0);
      cycle();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
